// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt
  } state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch, issue/commit and trace signals of the PC sequencer; master is the sequencer side.
interface pc_sequencer_if #(
  parameter int unsigned REG_BITS = 32
);
  logic                imem_req;
  logic [REG_BITS-1:0] imem_addr;
  logic                imem_ack;
  logic [REG_BITS-1:0] imem_rdata;
  logic                inst_valid;
  logic [REG_BITS-1:0] inst;
  logic [REG_BITS-1:0] pc;
  logic                commit;
  logic                branch;
  logic [REG_BITS-1:0] branch_target;
  logic                halt;
  logic                halted;
  logic [REG_BITS-1:0] retired_cnt;
  logic [REG_BITS-1:0] taken_cnt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc, halted, retired_cnt, taken_cnt,
    input  imem_ack, imem_rdata, commit, branch, branch_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc, halted, retired_cnt, taken_cnt,
    output imem_ack, imem_rdata, commit, branch, branch_target, halt
  );
endinterface

// File: rtl/pc_sequencer_pc_next_sel.sv
// Next-PC select: sequential PC+4 or word-aligned branch target.
module pc_sequencer_pc_next_sel
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned REG_BITS = 32
) (
  input  logic [REG_BITS-1:0] pc_i,
  input  logic [REG_BITS-1:0] target_i,
  input  logic                branch_i,
  output logic [REG_BITS-1:0] pc_next_o
);

  localparam logic [REG_BITS-1:0] AlignMask = ~REG_BITS'(3);
  localparam logic [REG_BITS-1:0] Inc       = REG_BITS'(PC_INC);

  // Misaligned targets are silently rounded down, never faulted.
  assign pc_next_o = branch_i ? (target_i & AlignMask) : (pc_i + Inc);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: fetch handshake, instruction hold and branch-resolved PC update.
// Optional retired/taken trace counters are built when PC_TRACE_EN is defined.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned         REG_BITS = 32,
  parameter logic [REG_BITS-1:0] RESET_PC = REG_BITS'(RESET_PC_DEFAULT)
) (
  input  logic           clk,
  input  logic           reset_n,
  pc_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [REG_BITS-1:0] pc_q, pc_d;
  logic [REG_BITS-1:0] inst_q, inst_d;
  logic [REG_BITS-1:0] pc_next;
  logic                fetch_acc;
  logic                commit_acc;

  // Handshake inputs only count in the state that owns them.
  assign fetch_acc  = (state_q == StFetch) && bus.imem_ack;
  assign commit_acc = (state_q == StIssue) && bus.commit;

  pc_sequencer_pc_next_sel #(
    .REG_BITS (REG_BITS)
  ) u_pc_next_sel (
    .pc_i      (pc_q),
    .target_i  (bus.branch_target),
    .branch_i  (bus.branch),
    .pc_next_o (pc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = commit_acc ? pc_next : pc_q;
    inst_d  = fetch_acc ? bus.imem_rdata : inst_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (bus.imem_ack) state_d = StIssue;
      StIssue: if (bus.commit) state_d = bus.halt ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.inst_valid = 1'b0;
    bus.halted     = 1'b0;
    unique case (state_q)
      StFetch: bus.imem_req   = 1'b1;
      StIssue: bus.inst_valid = 1'b1;
      StHalt:  bus.halted     = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.inst      = inst_q;

`ifdef PC_TRACE_EN
  logic [REG_BITS-1:0] retired_q, taken_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else if (commit_acc) begin
      retired_q <= retired_q + REG_BITS'(1);
      if (bus.branch) taken_q <= taken_q + REG_BITS'(1);
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.taken_cnt   = taken_q;
`else
  assign bus.retired_cnt = '0;
  assign bus.taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed corner steps plus randomized fetch/commit rounds.
module tb_pc_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_retired;
  logic [31:0] exp_taken;
  logic        exp_halted;

  pc_sequencer_if #(.REG_BITS(32)) bus ();

  pc_sequencer #(
    .REG_BITS (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PC_TRACE_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic check_all(input string ctx, input bit req, input bit ivalid);
    chk({ctx, ".imem_req"},    {31'h0, bus.imem_req},   {31'h0, req});
    chk({ctx, ".imem_addr"},   bus.imem_addr,           exp_pc);
    chk({ctx, ".inst_valid"},  {31'h0, bus.inst_valid}, {31'h0, ivalid});
    chk({ctx, ".inst"},        bus.inst,                exp_inst);
    chk({ctx, ".pc"},          bus.pc,                  exp_pc);
    chk({ctx, ".halted"},      {31'h0, bus.halted},     {31'h0, exp_halted});
    chk({ctx, ".retired_cnt"}, bus.retired_cnt,         cnt_exp(exp_retired));
    chk({ctx, ".taken_cnt"},   bus.taken_cnt,           cnt_exp(exp_taken));
  endtask

  task automatic model_reset();
    exp_pc      = 32'h0;
    exp_inst    = 32'h0;
    exp_retired = 32'h0;
    exp_taken   = 32'h0;
    exp_halted  = 1'b0;
  endtask

  // Assert reset, then release it (optionally with a stale ack pending) and land in fetch.
  task automatic do_reset(input bit ack_pending);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset", 1'b0, 1'b0);
    tick();
    bus.imem_ack   = ack_pending;
    bus.imem_rdata = 32'hDEAD_BEEF;
    reset_n        = 1'b1;
    tick();
    check_all("fetch_entry", 1'b1, 1'b0);
    bus.imem_ack = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] data, input int wait_cyc, input bit strays);
    for (int i = 0; i < wait_cyc; i++) begin
      bus.commit = strays ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.halt   = strays ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.branch = strays;
      bus.branch_target = $urandom;
      tick();
      bus.commit = 1'b0;
      bus.halt   = 1'b0;
      bus.branch = 1'b0;
      check_all("fetch_wait", 1'b1, 1'b0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    exp_inst       = data;
    check_all("issue", 1'b0, 1'b1);
  endtask

  task automatic do_commit(input bit br, input logic [31:0] tgt, input bit hlt, input bit stray);
    if (stray) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = $urandom;
      tick();
      bus.imem_ack = 1'b0;
      check_all("issue_stray_ack", 1'b0, 1'b1);
    end
    bus.commit        = 1'b1;
    bus.branch        = br;
    bus.branch_target = tgt;
    bus.halt          = hlt;
    tick();
    bus.commit = 1'b0;
    bus.branch = 1'b0;
    bus.halt   = 1'b0;
    exp_pc      = br ? (tgt & 32'hFFFF_FFFC) : (exp_pc + 32'd4);
    exp_retired = exp_retired + 32'd1;
    exp_taken   = exp_taken + {31'h0, br};
    exp_halted  = hlt;
    check_all(hlt ? "halt_commit" : "commit", !hlt, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.commit        = 1'b0;
    bus.branch        = 1'b0;
    bus.branch_target = 32'h0;
    bus.halt          = 1'b0;
    model_reset();

    do_reset(1'b1);
    do_fetch(32'h0000_1234, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_commit(1'b0, 32'h0, 1'b0, 1'b0);
      do_fetch($urandom, 1, 1'b0);
    end
    do_commit(1'b0, 32'h0, 1'b0, 1'b0);
    do_fetch($urandom, 0, 1'b0);
    do_commit(1'b1, 32'h0000_0203, 1'b0, 1'b0);
    do_fetch($urandom, 0, 1'b0);
    do_commit(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_fetch($urandom, 1, 1'b0);
    do_commit(1'b0, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom, int'($urandom_range(0, 3)), 1'b1);
      do_commit(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end

    do_fetch($urandom, 1, 1'b1);
    do_commit(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      bus.commit     = 1'($urandom_range(0, 1));
      bus.branch     = 1'($urandom_range(0, 1));
      bus.branch_target = $urandom;
      tick();
      check_all("halted_hold", 1'b0, 1'b0);
    end
    bus.imem_ack = 1'b0;
    bus.commit   = 1'b0;
    bus.branch   = 1'b0;

    do_reset(1'b1);
    do_fetch(32'hCAFE_0001, 0, 1'b0);
    do_commit(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_reset_pc", bus.pc, 32'h4);
    do_reset(1'b0);
    do_fetch(32'h0000_00AA, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
